// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_seq_pkg: shared ALU opcodes, funct codes, hilo_sel codes and FSM states
package alu_ctrl_seq_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111,
    OP_SLL = 3'b100
  } alu_opn_e;
  typedef enum logic [1:0] {HS_ALU = 2'b00, HS_HI = 2'b01, HS_LO = 2'b10} hilo_sel_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_ANDI  = 2'b11;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  function automatic logic hilo_dep(logic [5:0] f);
    return f == F_MULTU || f == F_DIVU || f == F_MFHI || f == F_MFLO;
  endfunction
endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-stage instruction fields and control outputs
interface alu_ctrl_seq_if;
  logic       valid;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [2:0] alu_operation;
  logic [1:0] hilo_sel;
  logic       md_start;
  logic       md_step;
  logic       md_mode;
  logic       hilo_we;
  logic       busy;
  logic       stall;
  logic       illegal;
  modport master (
    output valid, alu_op, funct,
    input  alu_operation, hilo_sel, md_start, md_step, md_mode, hilo_we, busy, stall, illegal
  );
  modport slave (
    input  valid, alu_op, funct,
    output alu_operation, hilo_sel, md_start, md_step, md_mode, hilo_we, busy, stall, illegal
  );
endinterface

// File: rtl/md_seq_counter.sv
// md_seq_counter: iteration counter flagging the final multiply/divide step
module md_seq_counter #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign last = cnt == CW'(DATA_W - 1);
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with multi-cycle MULTU/DIVU sequencer
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit SUPPORT_DIV = 1
) (
  input logic clk,
  input logic rst,
  alu_ctrl_seq_if.slave bus
);
  alu_opn_e  op;
  hilo_sel_e hs;
  state_e    state, nxt;
  logic      ill, rtype, go, last, md_mode, md_start;
  assign rtype = bus.alu_op == AOP_RTYPE;
  always_comb begin
    op  = OP_AND;
    hs  = HS_ALU;
    ill = 1'b0;
    case (bus.alu_op)
      AOP_ADD:  op = OP_ADD;
      AOP_SUB:  op = OP_SUB;
      AOP_ANDI: op = OP_AND;
      default: case (bus.funct)
        F_ADD:          op = OP_ADD;
        F_SUB:          op = OP_SUB;
        F_AND, F_MULTU: op = OP_AND;
        F_OR:           op = OP_OR;
        F_SLT:          op = OP_SLT;
        F_SLL:          op = OP_SLL;
        F_DIVU:         ill = !SUPPORT_DIV;
        F_MFHI:         hs = HS_HI;
        F_MFLO:         hs = HS_LO;
        default:        ill = 1'b1;
      endcase
    endcase
  end
  assign go = bus.valid && rtype && state == IDLE &&
              (bus.funct == F_MULTU || (SUPPORT_DIV && bus.funct == F_DIVU));
  always_comb nxt = state == IDLE ? (go ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      md_mode  <= 1'b0;
      md_start <= 1'b0;
    end else begin
      state    <= nxt;
      md_start <= go;
      if (go) md_mode <= bus.funct == F_DIVU;
    end
  end
  md_seq_counter #(.DATA_W(DATA_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .en(state == RUN),
    .last(last)
  );
  assign bus.alu_operation = op;
  assign bus.hilo_sel      = hs;
  assign bus.illegal       = ill;
  assign bus.md_start      = md_start;
  assign bus.md_step       = state == RUN;
  assign bus.md_mode       = md_mode;
  assign bus.hilo_we       = state == DONE;
  assign bus.busy          = state != IDLE;
  assign bus.stall         = bus.valid && state != IDLE && rtype && hilo_dep(bus.funct);
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed vectors with a scoreboard on completed mul/div operations
module tb_alu_ctrl_seq;
  import alu_ctrl_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_ctrl_seq_if i0();
  alu_ctrl_seq_if i1();
  alu_ctrl_seq #(.DATA_W(8), .SUPPORT_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  alu_ctrl_seq #(.DATA_W(32), .SUPPORT_DIV(0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  int total = 0;
  int bad = 0;
  typedef struct packed {logic mode; logic [7:0] steps;} exp_t;
  exp_t sb[$];
  typedef struct {logic [1:0] op; logic [5:0] f; logic [2:0] aop; logic [1:0] hs; logic ill;} vec_t;
  vec_t tbl [15] = '{
    '{2'b00, 6'b000000, 3'b010, 2'b00, 1'b0},
    '{2'b01, 6'b000000, 3'b110, 2'b00, 1'b0},
    '{2'b11, 6'b111111, 3'b000, 2'b00, 1'b0},
    '{2'b10, 6'b100000, 3'b010, 2'b00, 1'b0},
    '{2'b10, 6'b100010, 3'b110, 2'b00, 1'b0},
    '{2'b10, 6'b100100, 3'b000, 2'b00, 1'b0},
    '{2'b10, 6'b100101, 3'b001, 2'b00, 1'b0},
    '{2'b10, 6'b101010, 3'b111, 2'b00, 1'b0},
    '{2'b10, 6'b000000, 3'b100, 2'b00, 1'b0},
    '{2'b10, 6'b011001, 3'b000, 2'b00, 1'b0},
    '{2'b10, 6'b011011, 3'b000, 2'b00, 1'b0},
    '{2'b10, 6'b010000, 3'b000, 2'b01, 1'b0},
    '{2'b10, 6'b010010, 3'b000, 2'b10, 1'b0},
    '{2'b10, 6'b111000, 3'b000, 2'b00, 1'b1},
    '{2'b10, 6'b000001, 3'b000, 2'b00, 1'b1}
  };
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic d0(logic v, logic [1:0] op, logic [5:0] f);
    i0.valid = v; i0.alu_op = op; i0.funct = f;
  endtask
  task automatic d1(logic v, logic [1:0] op, logic [5:0] f);
    i1.valid = v; i1.alu_op = op; i1.funct = f;
  endtask
  // Monitor: every hilo_we on dut0 must match the oldest expected operation
  int   msteps = 0;
  logic mmode = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) msteps = 0;
    else begin
      if (i0.md_start) begin
        msteps = 0;
        mmode = i0.md_mode;
      end else if (i0.md_step) chk("md_mode_hold", i0.md_mode, mmode);
      if (i0.md_step) msteps++;
      if (i0.hilo_we) begin
        if (sb.size() == 0) chk("unexpected_hilo_we", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_md_mode", mmode, e.mode);
          chk("sb_md_steps", msteps, e.steps);
        end
        msteps = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    d0(0, 0, 0);
    d1(0, 0, 0);
    repeat (3) tick();
    chk("rst_busy0", i0.busy, 0);
    chk("rst_step0", i0.md_step, 0);
    chk("rst_start0", i0.md_start, 0);
    chk("rst_we0", i0.hilo_we, 0);
    chk("rst_stall0", i0.stall, 0);
    chk("rst_mode0", i0.md_mode, 0);
    chk("rst_busy1", i1.busy, 0);
    rst = 1'b0;
    foreach (tbl[k]) begin
      tick();
      d0(0, tbl[k].op, tbl[k].f);
      #1;
      chk($sformatf("dec%0d_op", k), i0.alu_operation, tbl[k].aop);
      chk($sformatf("dec%0d_hs", k), i0.hilo_sel, tbl[k].hs);
      chk($sformatf("dec%0d_ill", k), i0.illegal, tbl[k].ill);
    end
    tick();
    chk("novalid_multu_busy", i0.busy, 0);
    d1(1, AOP_RTYPE, F_DIVU);
    #1;
    chk("nodiv_illegal", i1.illegal, 1);
    chk("nodiv_op", i1.alu_operation, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("nodiv_busy", i1.busy, 0);
    end
    d1(0, 0, 0);
    tick();
    d0(1, AOP_RTYPE, F_DIVU);
    sb.push_back('{1'b1, 8'd8});
    for (int c = 1; c <= 10; c++) begin
      tick();
      d0(1, AOP_RTYPE, F_MFLO);
      #1;
      if (c <= 9) begin
        chk($sformatf("divu_stall_c%0d", c), i0.stall, 1);
        chk($sformatf("divu_mode_c%0d", c), i0.md_mode, 1);
      end else begin
        chk("mflo_hilo_sel", i0.hilo_sel, 2);
        chk("mflo_stall", i0.stall, 0);
      end
    end
    tick();
    d0(0, 0, 0);
    tick();
    d0(1, AOP_RTYPE, F_MULTU);
    sb.push_back('{1'b0, 8'd8});
    sb.push_back('{1'b0, 8'd8});
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c >= 2 && c <= 4) begin
        d0(1, AOP_ADD, 6'b000000);
        #1;
        chk($sformatf("add_stall_c%0d", c), i0.stall, 0);
        chk($sformatf("add_op_c%0d", c), i0.alu_operation, OP_ADD);
      end else if (c == 5) begin
        d0(1, AOP_RTYPE, F_ADD);
        #1;
        chk("radd_stall", i0.stall, 0);
        chk("radd_op", i0.alu_operation, OP_ADD);
      end else if (c == 11) begin
        d0(0, 0, 0);
        #1;
        chk("restart_md_start", i0.md_start, 1);
        chk("restart_busy", i0.busy, 1);
      end else begin
        d0(1, AOP_RTYPE, F_MULTU);
        #1;
        chk($sformatf("multu_stall_c%0d", c), i0.stall, c <= 9);
      end
      if (c <= 10) chk($sformatf("multu_we_c%0d", c), i0.hilo_we, c == 9);
    end
    repeat (12) tick();
    d0(1, AOP_RTYPE, F_MULTU);
    tick();
    d0(0, 0, 0);
    repeat (4) tick();
    rst = 1'b1;
    chk("pre_rst_busy", i0.busy, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", i0.busy, 0);
    chk("abort_step", i0.md_step, 0);
    repeat (12) tick();
    d0(1, AOP_RTYPE, F_MULTU);
    sb.push_back('{1'b0, 8'd8});
    tick();
    d0(0, 0, 0);
    repeat (12) tick();
    d1(1, AOP_RTYPE, F_MULTU);
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) d1(0, 0, 0);
      #1;
      chk($sformatf("w32_start_c%0d", c), i1.md_start, c == 1);
      chk($sformatf("w32_step_c%0d", c), i1.md_step, c <= 32);
      chk($sformatf("w32_we_c%0d", c), i1.hilo_we, c == 33);
      chk($sformatf("w32_busy_c%0d", c), i1.busy, c <= 33);
    end
    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; sets multi-cycle iteration count (legal 8..64).
REQ-002 Parameter SUPPORT_DIV, default 1: 1 = DIVU decoded and sequenced; 0 = DIVU illegal.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 valid  in  1  instruction in decode is real; when 0, no sequencing starts and stall is 0.
REQ-007 alu_op  in  2  main-control class: 00 add, 01 sub, 11 andi, 10 R-type.
REQ-008 funct  in  6  R-type function field.
REQ-009 alu_operation  out  3  ALU select: AND 000, OR 001, ADD 010, SUB 110, SLT 111, SLL 100.
REQ-010 hilo_sel  out  2  result mux: 00 ALU, 01 HI, 10 LO.
REQ-011 md_start  out  1  one-cycle pulse that loads the multiply/divide unit.
REQ-012 md_step  out  1  one iteration of the shift-add / shift-subtract unit this cycle.
REQ-013 md_mode  out  1  0 multiply, 1 divide; held constant for the whole operation.
REQ-014 hilo_we  out  1  one-cycle pulse writing HI/LO.
REQ-015 busy  out  1  multi-cycle operation in progress.
REQ-016 stall  out  1  decode must hold the current instruction.
REQ-017 illegal  out  1  unrecognised alu_op/funct combination.

Function
REQ-018 Decoding is combinational from alu_op/funct: 00 ADD, 01 SUB, 11 AND; for 10, funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL.
REQ-019 Recognised R-type funct codes also include MULTU 011001, DIVU 011011, MFHI 010000 (hilo_sel=01) and MFLO 010010 (hilo_sel=10); hilo_sel=00 for every other code.
REQ-020 Unrecognised combination, or DIVU with SUPPORT_DIV=0: illegal=1, alu_operation=000, no sequencing; alu_operation never X.
REQ-021 FSM states: IDLE, RUN, DONE; counter width clog2(DATA_W+1).
REQ-022 IDLE -> RUN at edge T when valid and funct is MULTU or legal DIVU (alu_op=10); md_mode is latched at that edge and counter is cleared.
REQ-023 First RUN cycle (T+1): md_start=1, md_step=1; md_step stays 1 for exactly DATA_W cycles (T+1..T+DATA_W).
REQ-024 RUN -> DONE when counter reaches DATA_W-1; in DONE (T+DATA_W+1), hilo_we=1 for that cycle only; DONE -> IDLE unconditionally.
REQ-025 busy=1 whenever state is not IDLE; md_start, md_step and hilo_we are 0 in IDLE.
REQ-026 stall=1 when valid, state is not IDLE, and funct is MULTU, DIVU, MFHI or MFLO with alu_op=10; all other instructions proceed unstalled during RUN.
REQ-027 A MULTU/DIVU presented while busy does not restart the counter; it starts from IDLE on the edge after DONE.
REQ-028 MFHI/MFLO presented during DONE stalls; it is released in the next cycle, after HI/LO has been written.
REQ-029 valid=0 in IDLE with a MULTU funct: no transition.

Reset
REQ-030 rst=1 at an edge: state=IDLE, counter=0, md_mode=0; md_start, md_step, hilo_we, busy and stall are 0 from the following cycle.
REQ-031 Reset mid-RUN or in DONE aborts the operation with no hilo_we pulse; HI/LO contents are not this block's concern.

Structure
REQ-032 A shared package holds the ALU operation codes, funct codes, hilo_sel codes and the FSM state enumeration.
REQ-033 One sub-module, md_seq_counter (parametrised by DATA_W; ports clr, en, last), is natural; decoding stays in the top module.

Verification
REQ-034 alu_op=10, funct=101010 -> alu_operation=111, illegal=0; alu_op=10, funct=111000 -> illegal=1, alu_operation=000.
REQ-035 DATA_W=32, valid MULTU at edge 0 -> md_start at cycle 1, md_step count=32 (cycles 1..32), hilo_we at cycle 33 only, busy=0 at cycle 34.
REQ-036 DATA_W=8, DIVU then MFLO the next cycle -> md_mode=1, stall=1 for cycles 1..9, hilo_sel=10 and stall=0 at cycle 10.
REQ-037 ADD issued during RUN -> stall=0, alu_operation=010, counter unaffected.
REQ-038 rst pulsed at cycle 5 of MULTU -> busy=0 at cycle 6, no hilo_we ever; next MULTU restarts with full DATA_W steps.
REQ-039 SUPPORT_DIV=0, valid DIVU -> illegal=1, busy stays 0.
